// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//   Writeback stage and architectural register file of the pipelined Y86-64
//   core. It takes the W pipeline register outputs, works out the effective
//   E/M destinations, commits valE/valM into r0..r14, serves the two decode
//   read ports, exports the W-stage forwarding sources, latches the program
//   status and counts retired instructions.
//
// Ports
//   clk, rst_n             clock and synchronous active-low reset
//   w_stat/w_icode/w_rA/w_rB/w_cnd/w_valE/w_valM
//                          W-stage pipeline register outputs
//   d_srcA/d_srcB          decode read addresses (0xF = none)
//   d_rvalA/d_rvalB        combinational read data (0 for address 0xF)
//   wb_dstE/wb_dstM        effective destinations, 0xF when nothing commits
//   wb_valE/wb_valM        forwarding sources (pass-through of W values)
//   prog_stat              latched program status
//   halted                 sticky flag, set once a fault/halt status retires
//   retired                retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module wb_regfile #(
    parameter int DW   = 64,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      w_stat,
    input  logic [3:0]      w_icode,
    input  logic [3:0]      w_rA,
    input  logic [3:0]      w_rB,
    input  logic            w_cnd,
    input  logic [DW-1:0]   w_valE,
    input  logic [DW-1:0]   w_valM,
    input  logic [3:0]      d_srcA,
    input  logic [3:0]      d_srcB,
    output logic [DW-1:0]   d_rvalA,
    output logic [DW-1:0]   d_rvalB,
    output logic [3:0]      wb_dstE,
    output logic [3:0]      wb_dstM,
    output logic [DW-1:0]   wb_valE,
    output logic [DW-1:0]   wb_valM,
    output logic [2:0]      prog_stat,
    output logic            halted,
    output logic [CNTW-1:0] retired
);

    localparam logic [2:0] ST_BUB = 3'd0;
    localparam logic [2:0] ST_AOK = 3'd1;
    localparam logic [2:0] ST_HLT = 3'd2;
    localparam logic [2:0] ST_ADR = 3'd3;
    localparam logic [2:0] ST_INS = 3'd4;
    localparam logic [3:0] RNONE  = 4'hF;
    localparam logic [3:0] RRSP   = 4'h4;

    logic [DW-1:0]   regs_q [0:14];
    logic [2:0]      prog_stat_q, prog_stat_d;
    logic            halted_q, halted_d;
    logic [CNTW-1:0] retired_q, retired_d;

    logic [3:0] dst_e, dst_m;
    logic       commit_en;
    logic       fault_ev;

    // Raw destination decode from the instruction code.
    always_comb begin
        dst_e = RNONE;
        dst_m = RNONE;
        case (w_icode)
            4'h2:                      dst_e = w_cnd ? w_rB : RNONE;
            4'h3, 4'h6:                dst_e = w_rB;
            4'h8, 4'h9, 4'hA, 4'hB:    dst_e = RRSP;
            default:                   dst_e = RNONE;
        endcase
        if (w_icode == 4'h5 || w_icode == 4'hB) begin
            dst_m = w_rA;
        end
    end

    // Only AOK instructions commit, and nothing commits once halted.
    // A bubble is neither a commit nor a status event.
    assign commit_en = (w_stat == ST_AOK) && !halted_q;
    assign fault_ev  = !halted_q &&
                       (w_stat == ST_HLT || w_stat == ST_ADR || w_stat == ST_INS);

    assign wb_dstE = commit_en ? dst_e : RNONE;
    assign wb_dstM = commit_en ? dst_m : RNONE;
    assign wb_valE = w_valE;
    assign wb_valM = w_valM;

    always_comb begin
        prog_stat_d = prog_stat_q;
        halted_d    = halted_q;
        retired_d   = retired_q;
        if (fault_ev) begin
            prog_stat_d = w_stat;
            halted_d    = 1'b1;
        end
        // HLT itself retires; ADR/INS faults do not.
        if ((commit_en && w_icode != 4'h1) || (fault_ev && w_stat == ST_HLT)) begin
            retired_d = retired_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prog_stat_q <= ST_AOK;
            halted_q    <= 1'b0;
            retired_q   <= '0;
        end else begin
            prog_stat_q <= prog_stat_d;
            halted_q    <= halted_d;
            retired_q   <= retired_d;
        end
    end

    // The M write is issued after the E write so that on a collision
    // (popq %rsp) the memory value is the one that lands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit_en) begin
            if (wb_dstE != RNONE) begin
                regs_q[wb_dstE] <= w_valE;
            end
            if (wb_dstM != RNONE) begin
                regs_q[wb_dstM] <= w_valM;
            end
        end
    end

    // Reads see the array only; same-cycle writes are not bypassed.
    assign d_rvalA = (d_srcA == RNONE) ? '0 : regs_q[d_srcA];
    assign d_rvalB = (d_srcB == RNONE) ? '0 : regs_q[d_srcB];

    assign prog_stat = prog_stat_q;
    assign halted    = halted_q;
    assign retired   = retired_q;

    logic unused_bub;
    assign unused_bub = (ST_BUB == 3'd0);

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  w_stat;
    logic [3:0]  w_icode, w_rA, w_rB;
    logic        w_cnd;
    logic [63:0] w_valE, w_valM;
    logic [3:0]  d_srcA, d_srcB;
    logic [63:0] d_rvalA, d_rvalB, wb_valE, wb_valM;
    logic [3:0]  wb_dstE, wb_dstM;
    logic [2:0]  prog_stat;
    logic        halted;
    logic [31:0] retired;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_regfile #(.DW(64), .CNTW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .w_stat(w_stat), .w_icode(w_icode), .w_rA(w_rA), .w_rB(w_rB),
        .w_cnd(w_cnd), .w_valE(w_valE), .w_valM(w_valM),
        .d_srcA(d_srcA), .d_srcB(d_srcB),
        .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
        .wb_dstE(wb_dstE), .wb_dstM(wb_dstM),
        .wb_valE(wb_valE), .wb_valM(wb_valM),
        .prog_stat(prog_stat), .halted(halted), .retired(retired)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after posedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] ra,
                         input logic [3:0] rb, input logic cnd,
                         input logic [63:0] ve, input logic [63:0] vm);
        w_stat = st; w_icode = ic; w_rA = ra; w_rB = rb; w_cnd = cnd;
        w_valE = ve; w_valM = vm;
    endtask

    task automatic bubble();
        drive(3'd0, 4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
    endtask

    task automatic read_a(input logic [3:0] r, input string tag, input logic [63:0] exp);
        d_srcA = r;
        #1;
        check(tag, d_rvalA, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        d_srcA = 4'hF;
        d_srcB = 4'hF;
        bubble();
        step();
        step();
        rst_n = 1'b1;

        // Reset state
        check("rst_prog_stat", {61'b0, prog_stat}, 64'd1);
        check("rst_halted", {63'b0, halted}, 64'd0);
        check("rst_retired", {32'b0, retired}, 64'd0);
        for (int i = 0; i < 15; i++) begin
            read_a(4'(i), $sformatf("rst_r%0d", i), 64'h0);
        end
        check("rst_srcB_none", d_rvalB, 64'h0);

        // irmovq $0x1234, %rdx
        drive(3'd1, 4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0);
        d_srcA = 4'h2;
        #1;
        check("irmov_dstE", {60'b0, wb_dstE}, 64'h2);
        check("irmov_dstM", {60'b0, wb_dstM}, 64'hF);
        check("irmov_fwdE", wb_valE, 64'h1234);
        check("irmov_same_cycle_old", d_rvalA, 64'h0);
        step();
        bubble();
        #1;
        check("irmov_r2", d_rvalA, 64'h1234);
        check("irmov_retired", {32'b0, retired}, 64'd1);
        d_srcB = 4'h2;
        #1;
        check("irmov_r2_portB", d_rvalB, 64'h1234);
        d_srcB = 4'hF;

        // cmovXX not taken then taken
        drive(3'd1, 4'h2, 4'h0, 4'h5, 1'b0, 64'h7, 64'h0);
        #1;
        check("cmov_nt_dstE", {60'b0, wb_dstE}, 64'hF);
        step();
        bubble();
        read_a(4'h5, "cmov_nt_r5", 64'h0);
        check("cmov_nt_retired", {32'b0, retired}, 64'd2);
        drive(3'd1, 4'h2, 4'h0, 4'h5, 1'b1, 64'h7, 64'h0);
        #1;
        check("cmov_t_dstE", {60'b0, wb_dstE}, 64'h5);
        step();
        bubble();
        read_a(4'h5, "cmov_t_r5", 64'h7);
        check("cmov_t_retired", {32'b0, retired}, 64'd3);

        // popq %rsp: E and M both target r4, M must win
        drive(3'd1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'hAB);
        #1;
        check("pop_dstE", {60'b0, wb_dstE}, 64'h4);
        check("pop_dstM", {60'b0, wb_dstM}, 64'h4);
        check("pop_fwdM", wb_valM, 64'hAB);
        step();
        bubble();
        read_a(4'h4, "pop_r4", 64'hAB);
        check("pop_retired", {32'b0, retired}, 64'd4);

        // Bubbles carrying a would-be write, and nops: no writes, no count
        drive(3'd0, 4'h3, 4'hF, 4'h6, 1'b0, 64'h99, 64'h0);
        #1;
        check("bub_dstE", {60'b0, wb_dstE}, 64'hF);
        step();
        step();
        drive(3'd1, 4'h1, 4'hF, 4'hF, 1'b0, 64'h55, 64'h66);
        step();
        step();
        step();
        bubble();
        read_a(4'h6, "bub_r6", 64'h0);
        check("bubnop_retired", {32'b0, retired}, 64'd4);
        check("bubnop_prog_stat", {61'b0, prog_stat}, 64'd1);

        // mrmovq with ADR fault
        drive(3'd3, 4'h5, 4'h3, 4'h1, 1'b0, 64'h10, 64'h9);
        #1;
        check("adr_dstM", {60'b0, wb_dstM}, 64'hF);
        step();
        bubble();
        read_a(4'h3, "adr_r3", 64'h0);
        check("adr_prog_stat", {61'b0, prog_stat}, 64'd3);
        check("adr_halted", {63'b0, halted}, 64'd1);
        check("adr_retired", {32'b0, retired}, 64'd4);

        // Sticky halt: later AOK write and HLT are ignored
        drive(3'd1, 4'h3, 4'hF, 4'h3, 1'b0, 64'h55, 64'h0);
        #1;
        check("halt_dstE", {60'b0, wb_dstE}, 64'hF);
        step();
        drive(3'd2, 4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
        step();
        bubble();
        read_a(4'h3, "halt_r3", 64'h0);
        check("halt_retired", {32'b0, retired}, 64'd4);
        check("halt_prog_stat", {61'b0, prog_stat}, 64'd3);

        // Reset clears the halt and the register file
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        read_a(4'h2, "rst2_r2", 64'h0);
        read_a(4'h4, "rst2_r4", 64'h0);
        check("rst2_halted", {63'b0, halted}, 64'd0);
        check("rst2_prog_stat", {61'b0, prog_stat}, 64'd1);

        // OPq write to r7, then reset asserted during a write to r8
        drive(3'd1, 4'h6, 4'h1, 4'h7, 1'b0, 64'h77, 64'h0);
        step();
        read_a(4'h7, "op_r7", 64'h77);
        check("op_retired", {32'b0, retired}, 64'd1);
        drive(3'd1, 4'h3, 4'hF, 4'h8, 1'b0, 64'h88, 64'h0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bubble();
        read_a(4'h8, "rstw_r8", 64'h0);
        read_a(4'h7, "rstw_r7", 64'h0);
        check("rstw_retired", {32'b0, retired}, 64'd0);

        // HLT retires, counts, and latches status
        drive(3'd2, 4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
        step();
        bubble();
        #1;
        check("hlt_prog_stat", {61'b0, prog_stat}, 64'd2);
        check("hlt_halted", {63'b0, halted}, 64'd1);
        check("hlt_retired", {32'b0, retired}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
